// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: light codes,
// approach indices and the phase state encoding.
package traffic_pkg;

  localparam logic [3:0] RED    = 4'b0001;
  localparam logic [3:0] GREEN  = 4'b0010;
  localparam logic [3:0] YELLOW = 4'b0100;

  localparam logic [1:0] NS1 = 2'd0;
  localparam logic [1:0] NS2 = 2'd1;
  localparam logic [1:0] EW1 = 2'd2;
  localparam logic [1:0] EW2 = 2'd3;

  typedef enum logic [1:0] {
    StAllRed = 2'd0,
    StGreen  = 2'd1,
    StYellow = 2'd2
  } phase_state_e;

endpackage

// File: rtl/rr_demand_arbiter.sv
// Latches per-approach demand and picks the next approach to serve,
// searching round-robin from the slot after the last grant.
module rr_demand_arbiter
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       grant,
  output logic [3:0] pending,
  output logic [1:0] winner,
  output logic       any_pending
);

  logic       found;
  logic [1:0] idx;
  logic [3:0] clear_mask;

  always_comb begin
    winner = ptr + 2'd1;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_pending = |pending;

  // Clearing the granted approach takes priority over a coincident request.
  always_comb begin
    clear_mask = '0;
    if (grant) clear_mask[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending | req) & ~clear_mask;
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Adaptive four-approach phase scheduler: round-robin grants with minimum
// green, congestion-driven extension, yellow and all-red clearance.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALL_RED_T = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       cong,
  output logic [1:0]       active,
  output logic [3:0]       light_signal,
  output logic [CNT_W-1:0] timer,
  output logic [3:0]       pending,
  output logic             phase_done
);

  localparam logic [CNT_W-1:0] MinLast    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxLast    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALL_RED_T - 1);

  phase_state_e state;
  logic [1:0]   ptr;
  logic [1:0]   winner;
  logic         any_pending;
  logic         grant;

  assign grant = (state == StAllRed) && (timer >= AllRedLast) && any_pending;

  rr_demand_arbiter u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ptr         (ptr),
    .grant       (grant),
    .pending     (pending),
    .winner      (winner),
    .any_pending (any_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StAllRed;
      active       <= NS1;
      ptr          <= EW2;
      timer        <= '0;
      light_signal <= RED;
      phase_done   <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      unique case (state)
        StAllRed: begin
          if (grant) begin
            active       <= winner;
            ptr          <= winner;
            timer        <= '0;
            state        <= StGreen;
            light_signal <= GREEN;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        StGreen: begin
          // Only the active approach's congestion can extend its own green.
          if ((timer >= MinLast && !cong[active]) || timer == MaxLast) begin
            timer        <= '0;
            state        <= StYellow;
            light_signal <= YELLOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StYellow: begin
          if (timer == YellowLast) begin
            timer        <= '0;
            state        <= StAllRed;
            light_signal <= RED;
            phase_done   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer        <= '0;
          state        <= StAllRed;
          light_signal <= RED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed self-checking bench for phase_scheduler with default timing.
module tb_phase_scheduler;

  localparam logic [3:0] L_RED    = 4'b0001;
  localparam logic [3:0] L_GREEN  = 4'b0010;
  localparam logic [3:0] L_YELLOW = 4'b0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] cong = '0;
  logic [1:0] active;
  logic [3:0] light_signal;
  logic [7:0] timer;
  logic [3:0] pending;
  logic       phase_done;

  int n_checks = 0;
  int n_fail   = 0;

  phase_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .cong         (cong),
    .active       (active),
    .light_signal (light_signal),
    .timer        (timer),
    .pending      (pending),
    .phase_done   (phase_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Number of consecutive sample points showing the given light code.
  task automatic measure(input logic [3:0] code, output int n);
    n = 0;
    while (light_signal === code && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic wait_light(input string tag, input logic [3:0] code);
    int n;
    n = 0;
    while (light_signal !== code && n < 200) begin
      n++;
      step();
    end
    check(tag, 32'(light_signal), 32'(code));
  endtask

  task automatic wait_timer(input string tag, input logic [7:0] t);
    int n;
    n = 0;
    while (timer !== t && n < 100) begin
      n++;
      step();
    end
    check(tag, 32'(timer), 32'(t));
  endtask

  initial begin
    int n;
    bit bad_light, bad_done, bad_active;

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_light", 32'(light_signal), 32'(L_RED));
    check("rst_active", 32'(active), 0);
    check("rst_timer", 32'(timer), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_done", 32'(phase_done), 0);

    // Idle for 100 cycles
    bad_light = 0; bad_done = 0; bad_active = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (light_signal !== L_RED) bad_light = 1;
      if (phase_done !== 1'b0) bad_done = 1;
      if (active !== 2'd0) bad_active = 1;
    end
    check("idle_light", 32'(bad_light), 0);
    check("idle_done", 32'(bad_done), 0);
    check("idle_active", 32'(bad_active), 0);

    // Single EW1 pulse
    req = 4'b0100;
    step();
    req = 4'b0000;
    check("p1_pending_set", 32'(pending), 32'h4);
    check("p1_still_red", 32'(light_signal), 32'(L_RED));
    step();
    check("p1_green", 32'(light_signal), 32'(L_GREEN));
    check("p1_active", 32'(active), 2);
    check("p1_timer0", 32'(timer), 0);
    check("p1_pending_clr", 32'(pending), 0);
    measure(L_GREEN, n);
    check("p1_green_len", 32'(n), 10);
    check("p1_yellow", 32'(light_signal), 32'(L_YELLOW));
    measure(L_YELLOW, n);
    check("p1_yellow_len", 32'(n), 4);
    check("p1_red", 32'(light_signal), 32'(L_RED));
    check("p1_done_pulse", 32'(phase_done), 1);
    step();
    check("p1_done_once", 32'(phase_done), 0);
    for (int i = 0; i < 20; i++) step();
    check("p1_red_hold", 32'(light_signal), 32'(L_RED));
    check("p1_active_hold", 32'(active), 2);

    // Congested NS2: green stretches to the maximum
    cong = 4'b0010;
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check("c1_active", 32'(active), 1);
    measure(L_GREEN, n);
    check("c1_green_len", 32'(n), 40);
    check("c1_yellow", 32'(light_signal), 32'(L_YELLOW));
    measure(L_YELLOW, n);
    for (int i = 0; i < 5; i++) step();

    // Congestion dropped at green cycle 15
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check("c2_green", 32'(light_signal), 32'(L_GREEN));
    wait_timer("c2_reach14", 8'd14);
    cong = 4'b0000;
    step();
    check("c2_yellow", 32'(light_signal), 32'(L_YELLOW));
    check("c2_timer0", 32'(timer), 0);
    wait_light("c2_back_red", L_RED);

    // All four at once after reset: served 0,1,2,3
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    req = 4'b0000;
    step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d_green", k), 32'(light_signal), 32'(L_GREEN));
      check($sformatf("rr%0d_active", k), 32'(active), 32'(k));
      measure(L_GREEN, n);
      check($sformatf("rr%0d_green_len", k), 32'(n), 10);
      measure(L_YELLOW, n);
      check($sformatf("rr%0d_yellow_len", k), 32'(n), 4);
      if (k < 3) begin
        measure(L_RED, n);
        check($sformatf("rr%0d_red_len", k), 32'(n), 2);
      end
    end
    for (int i = 0; i < 30; i++) step();
    check("rr_idle_red", 32'(light_signal), 32'(L_RED));
    check("rr_idle_pending", 32'(pending), 0);

    // Demand for NS1 and EW2 during EW1 green: EW2 next, then NS1
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    check("o_active_ew1", 32'(active), 2);
    step(); step();
    req = 4'b1001;
    step();
    req = 4'b0000;
    check("o_pending", 32'(pending), 32'h9);
    wait_light("o_y1", L_YELLOW);
    wait_light("o_g2", L_GREEN);
    check("o_active_ew2", 32'(active), 3);
    wait_light("o_y2", L_YELLOW);
    wait_light("o_g3", L_GREEN);
    check("o_active_ns1", 32'(active), 0);
    wait_light("o_red", L_RED);

    // Reset mid-green discards pending demand
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check("r_active", 32'(active), 1);
    wait_timer("r_reach3", 8'd3);
    req = 4'b1000;
    step();
    req = 4'b0000;
    wait_timer("r_reach5", 8'd5);
    check("r_pending_pre", 32'(pending), 32'h8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_light", 32'(light_signal), 32'(L_RED));
    check("r_timer", 32'(timer), 0);
    check("r_pending", 32'(pending), 0);
    check("r_active0", 32'(active), 0);
    check("r_done", 32'(phase_done), 0);

    // Pointer restarts at NS1; clear wins over a coincident request
    req = 4'b0101;
    step(); step();
    req = 4'b0000;
    check("r_grant_ns1", 32'(active), 0);
    check("r_clear_wins", 32'(pending), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Adaptive phase scheduler that shares the intersection between four approaches (NS1, NS2, EW1, EW2). It latches vehicle demand, grants green to one approach at a time in round-robin order, and times each phase: minimum green, congestion-driven extension up to a maximum, yellow, then all-red clearance. It sits above the per-lane light FSM and drives the approach selection and light code that the signal heads consume.

## Interface
- CNT_W, 8, phase timer width.
- MIN_GREEN, 10, minimum green length in cycles (≥1).
- MAX_GREEN, 40, maximum green length in cycles (≥MIN_GREEN).
- YELLOW_T, 4, yellow length in cycles (≥1).
- ALL_RED_T, 2, minimum all-red clearance in cycles (≥1).
- Constraint: every timing parameter is < 2^CNT_W.
- clk  in  1  system clock, the only clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  4  demand pulses or levels, bit0 NS1, bit1 NS2, bit2 EW1, bit3 EW2.
- cong  in  4  congestion sensors, same bit order.
- active  out  2  approach currently owning the phase.
- light_signal  out  4  light code: 0001 red, 0010 green, 0100 yellow.
- timer  out  CNT_W  cycles elapsed in the current state.
- pending  out  4  latched unserved demand.
- phase_done  out  1  one-cycle pulse on YELLOW→ALL_RED.

## Operation
- States: ALL_RED, GREEN, YELLOW.
- Demand latch: pending[i] is set by req[i]=1. It is cleared on the cycle approach i is granted. If req[i] and the grant for i coincide, clear wins. Sets for other approaches in that cycle still take effect.
- ALL_RED: timer increments, saturating at 2^CNT_W−1. Once timer ≥ ALL_RED_T−1 and pending≠0, grant the first set bit searching ptr+1, ptr+2, … modulo 4. On grant: active←winner, ptr←winner, timer←0, state GREEN. With no demand, ALL_RED holds indefinitely.
- GREEN: timer increments. Exit to YELLOW (timer←0) when either:
  - timer ≥ MIN_GREEN−1 and cong[active]=0, or
  - timer = MAX_GREEN−1, regardless of cong.
- Result: green lasts exactly MIN_GREEN cycles without congestion and never more than MAX_GREEN cycles. cong on other approaches is ignored.
- YELLOW: when timer = YELLOW_T−1, go to ALL_RED with timer←0 and pulse phase_done.
- light_signal decodes the state: ALL_RED→0001, GREEN→0010, YELLOW→0100. active keeps the last grant while in YELLOW and ALL_RED.
- Demand arriving during GREEN or YELLOW for the active approach re-latches and is served in a later round.

## Timing
- All outputs are registered and change only on clk rising edge.
- Reset values: state ALL_RED, active 0, ptr 3 (first search starts at NS1), timer 0, pending 0000, light_signal 0001, phase_done 0.
- Reset mid-phase: the cycle after rst is sampled high, all outputs hold reset values. Pending demand is discarded.
- Latency: a req sampled at edge n sets pending at n+1. If ALL_RED clearance is already met, GREEN is visible at n+2. The grant uses registered pending, not raw req.
- Full phase with no congestion: MIN_GREEN + YELLOW_T + ALL_RED_T cycles, i.e. 16 with defaults.
- Simultaneous demand on all approaches: served one per phase in ptr+1 order, with no starvation.

## Structure
- Shared package traffic_pkg holds:
  - light code constants RED/GREEN/YELLOW;
  - approach index constants NS1=0, NS2=1, EW1=2, EW2=3;
  - the phase state enum.
- Sub-module rr_demand_arbiter contains the pending latch plus the round-robin search from ptr+1. It takes the grant strobe as input and returns winner and any_pending.
- The top level holds the FSM and timer.

## Test plan
- No demand after reset for 100 cycles: light_signal stays 0001, phase_done stays 0, active=0.
- Single req[2] pulse, cong=0: active=2; green 10 cycles, yellow 4, all-red ≥2; phase_done pulses once; pending returns to 0000.
- req[1] with cong[1] held high: green lasts exactly 40 cycles, then yellow. With cong[1] dropped at green cycle 15, yellow starts the next cycle.
- req=1111 in one cycle: grants occur in order 0, 1, 2, 3, each a full 16-cycle phase, then idle in all-red.
- While EW1 (2) is green, pulse req[0] and req[3]: next grant is 3, then 0.
- Assert rst at green timer=5: the next cycle shows light_signal 0001, timer 0, pending 0000, active 0.
